mult_issue_sequencer: RTL

MULT_ISSUE_SEQUENCER -- requirements
Module: mult_issue_sequencer

---
 rtl/mult_pkg.sv | 20 ++
 rtl/operand_fifo.sv | 52 +++++
 rtl/mult_issue_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared defaults, state encoding and watchdog sizing
// for the multiplier issue sequencer.
package mult_pkg;

    localparam int WIDTH_DEF   = 8;
    localparam int TIMEOUT_DEF = 64;
    localparam int WDOG_W_DEF  = $clog2(TIMEOUT_DEF + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    function automatic int wdog_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/operand_fifo.sv
// Two-entry operand FIFO; push is refused while full,
// so a same-cycle pop never frees a slot early.
module operand_fifo #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mult_issue_sequencer.sv
// Feeds buffered operand pairs to a multicycle multiplier,
// guards each job with a watchdog and holds the result.
module mult_issue_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               mul_start,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_done,
    input  logic [2*WIDTH-1:0] mul_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic               out_err,
    output logic [7:0]         job_count
);

    localparam int WW = wdog_width(TIMEOUT);

    state_t             state;
    logic [WW-1:0]      wdog;
    logic [2*WIDTH-1:0] head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && !empty;

    operand_fifo #(
        .DW (2*WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({in_a, in_b}),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wdog        <= '0;
            mul_start   <= 1'b0;
            mul_a       <= '0;
            mul_b       <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
            out_err     <= 1'b0;
            job_count   <= 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        mul_a     <= head[2*WIDTH-1:WIDTH];
                        mul_b     <= head[WIDTH-1:0];
                        mul_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_start <= 1'b0;
                    wdog      <= WW'(TIMEOUT);
                    state     <= WAIT;
                end
                WAIT: begin
                    // A completion in the expiry cycle still counts as done.
                    if (mul_done) begin
                        out_product <= mul_product;
                        out_err     <= 1'b0;
                        out_valid   <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        wdog <= wdog - WW'(1);
                        if (wdog == WW'(1)) begin
                            out_product <= '0;
                            out_err     <= 1'b1;
                            out_valid   <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        job_count <= job_count + 8'd1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
